ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Two-port arbiter and sequencer for the single-port, combinational, level-sensitive data RAM in the RISC-V processor. It accepts requests from instruction fetch (port 0) and load/store (port 1) over valid/ready handshakes and grants one per access slot. It drives the RAM address, data and write-enable from registers so that write-enable is never asserted on an unstable address. It returns read data or a write acknowledgement on a per-port one-cycle response pulse.

## Interface
- `DEPTH`, 256: RAM words; RAM address width is `RAW = $clog2(DEPTH)`.
- `WIDTH`, 32: data word width.
- `AW`, 32: requester word-address width.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pN_valid` input 1 (N=0,1): request present.
- `pN_ready` output 1: request accepted this cycle.
- `pN_addr` input AW: word address.
- `pN_wdata` input WIDTH: write data.
- `pN_we` input 1: 1 = write, 0 = read.
- `pN_rsp_valid` output 1: one-cycle response pulse.
- `pN_rsp_rdata` output WIDTH: read data, or written data on a write.
- `pN_rsp_err` output 1: qualifies the response; address out of range.
- `ram_address` output RAW: to RAM `address`.
- `ram_dataIn` output WIDTH: to RAM `dataIn`.
- `ram_writeEnable` output 1: to RAM `writeEnable`.
- `ram_dataOut` input WIDTH: from RAM `dataOut`.

## Operation
- **FSM states:** IDLE and ACCESS. Reset enters IDLE.
- **IDLE:** if any `pN_valid` is high, grant one port.
  - `pN_ready` = (state==IDLE) && granted port N. It is combinational from the valids.
  - On accept, latch addr, wdata, we, the port id, and `err = (addr >= DEPTH)`. Go to ACCESS.
- **ACCESS (exactly 1 cycle):**
  - Drive `ram_address` from the latched address (low RAW bits) and `ram_dataIn` from the latched wdata.
  - `ram_writeEnable` = latched we && !err.
  - At the end of the cycle, capture `ram_dataOut` into `pN_rsp_rdata` of the granted port. On err, capture 0 instead.
  - Go to IDLE, and pulse `pN_rsp_valid` and `pN_rsp_err` for the next cycle.
- **Outside ACCESS:** `ram_writeEnable` is 0. `ram_address` and `ram_dataIn` hold their last values.
- **Grant policy (default):** fixed priority; port 1 (data) wins when both ports are valid.
- **Requester rule:** hold valid, addr, wdata and we stable until ready. Withdrawing valid before ready is permitted and leaves no state behind.
- **`pN_rsp_rdata`:** holds its value until the next response to that port.
- **Reset, all outputs:** `pN_rsp_valid`=0, `pN_rsp_err`=0, `pN_rsp_rdata`=0, `ram_address`=0, `ram_dataIn`=0, `ram_writeEnable`=0, `pN_ready`=0.
- **Reset during ACCESS:**
  - The access is dropped and no response is issued.
  - `ram_writeEnable` falls immediately (asynchronously).
  - The target word's content is undefined and must not be checked.

## Timing
- Request accepted in cycle N (IDLE, ready=1):
  - cycle N+1 is ACCESS;
  - cycle N+2 has `rsp_valid`=1 and the FSM is back in IDLE.
- A new accept can occur in cycle N+2, the same cycle as the previous response.
- Peak throughput is one access per 2 cycles. Latency is 2 cycles from accept to response.
- Read-after-write to the same address from either port returns the new data. Accesses are strictly serialized.
- At most one `pN_ready` and at most one `pN_rsp_valid` are high per cycle.

## Configuration
- **`RAM_ARB_ROUND_ROBIN_EN` defined:** round-robin grant.
  - A 1-bit last-grant pointer resets to 1.
  - On conflict, the port not granted last wins. The pointer updates on every accept, whether or not there was a conflict.
  - The first conflict after reset therefore goes to port 0.
- **Not defined:** fixed priority to port 1. No pointer register exists.

## Test plan
- **Basic read:** after reset, p0 reads addr 5, where RAM[5]=0xDEADBEEF.
  - Expect p0_ready in cycle N, ram_writeEnable=0 throughout, and p0_rsp_valid in N+2 with rdata 0xDEADBEEF and err=0.
- **Write then read:** p1 writes 0x12345678 to addr 10, then p0 reads addr 10.
  - Expect ram_writeEnable=1 only in the write's ACCESS cycle.
  - Expect p1 rsp rdata 0x12345678, and p0 rsp rdata 0x12345678 two cycles after the second accept.
- **Simultaneous requests:** both ports valid continuously, each reading addr 1.
  - Default build: p1 granted every slot and p0 starved.
  - With `RAM_ARB_ROUND_ROBIN_EN`: grants alternate p0, p1, p0, …, with one response every 2 cycles.
- **Out of range:** p1 writes addr 256 with DEPTH=256.
  - Expect ram_writeEnable to stay 0, p1_rsp_err=1 with rdata 0, and RAM contents unchanged.
- **Reset mid-access:** assert reset during ACCESS of a p0 read.
  - Expect all outputs at their reset values immediately, no p0_rsp_valid afterwards, and a normal read served on the first request after release.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Two-port valid/ready arbiter and sequencer for a single-port combinational data RAM.
// Optional RAM_ARB_ROUND_ROBIN_EN selects round-robin grant instead of fixed priority to port 1.
module ram_access_arbiter #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic [AW-1:0]            p0_addr,
    input  logic [WIDTH-1:0]         p0_wdata,
    input  logic                     p0_we,
    output logic                     p0_rsp_valid,
    output logic [WIDTH-1:0]         p0_rsp_rdata,
    output logic                     p0_rsp_err,

    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic [AW-1:0]            p1_addr,
    input  logic [WIDTH-1:0]         p1_wdata,
    input  logic                     p1_we,
    output logic                     p1_rsp_valid,
    output logic [WIDTH-1:0]         p1_rsp_rdata,
    output logic                     p1_rsp_err,

    output logic [$clog2(DEPTH)-1:0] ram_address,
    output logic [WIDTH-1:0]         ram_dataIn,
    output logic                     ram_writeEnable,
    input  logic [WIDTH-1:0]         ram_dataOut
);

    localparam int RAW = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]       state;
    logic             grant1;
    logic             accept;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             req_we;
    logic             req_in_range;
    logic             acc_port;
    logic             acc_err;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Pointer holds the port granted most recently; the other port wins a conflict.
    logic last_grant;

    always_comb begin
        if (p0_valid && p1_valid) begin
            grant1 = ~last_grant;
        end else begin
            grant1 = p1_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`else
    always_comb begin
        grant1 = p1_valid;
    end
`endif

    // Ready is gated by reset so no handshake completes while reset is held.
    always_comb begin
        accept   = !reset && (state == ST_IDLE) && (p0_valid || p1_valid);
        p0_ready = accept && !grant1;
        p1_ready = accept && grant1;
    end

    always_comb begin
        req_addr     = grant1 ? p1_addr  : p0_addr;
        req_wdata    = grant1 ? p1_wdata : p0_wdata;
        req_we       = grant1 ? p1_we    : p0_we;
        req_in_range = (req_addr < AW'(DEPTH));
    end

    // RAM controls are registered; write-enable is high only during ACCESS
    // and drops asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            acc_port        <= 1'b0;
            acc_err         <= 1'b0;
            ram_address     <= '0;
            ram_dataIn      <= '0;
            ram_writeEnable <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state           <= ST_ACCESS;
                        acc_port        <= grant1;
                        acc_err         <= !req_in_range;
                        ram_address     <= req_addr[RAW-1:0];
                        ram_dataIn      <= req_wdata;
                        ram_writeEnable <= req_we && req_in_range;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    ram_writeEnable <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_err   <= 1'b0;
            p0_rsp_rdata <= '0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_err   <= 1'b0;
            p1_rsp_rdata <= '0;
        end else begin
            p0_rsp_valid <= (state == ST_ACCESS) && !acc_port;
            p0_rsp_err   <= (state == ST_ACCESS) && !acc_port && acc_err;
            p1_rsp_valid <= (state == ST_ACCESS) && acc_port;
            p1_rsp_err   <= (state == ST_ACCESS) && acc_port && acc_err;
            if ((state == ST_ACCESS) && !acc_port) begin
                p0_rsp_rdata <= acc_err ? '0 : ram_dataOut;
            end
            if ((state == ST_ACCESS) && acc_port) begin
                p1_rsp_rdata <= acc_err ? '0 : ram_dataOut;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a behavioural combinational RAM.
// Expected responses are queued at accept and checked when the response pulse appears.
module tb_ram_access_arbiter;

    localparam int DEPTH = 256;
    localparam int WIDTH = 32;
    localparam int AW    = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
    logic [AW-1:0]     p0_addr;
    logic [WIDTH-1:0]  p0_wdata, p0_rsp_rdata;
    logic              p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
    logic [AW-1:0]     p1_addr;
    logic [WIDTH-1:0]  p1_wdata, p1_rsp_rdata;
    logic [7:0]        ram_address;
    logic [WIDTH-1:0]  ram_dataIn, ram_dataOut;
    logic              ram_writeEnable;

    ram_access_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_we(p0_we), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_we(p1_we), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .ram_address(ram_address), .ram_dataIn(ram_dataIn),
        .ram_writeEnable(ram_writeEnable), .ram_dataOut(ram_dataOut)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write committed mid-cycle while enabled.
    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    assign ram_dataOut = mem[ram_address];
    always @(negedge clk) if (ram_writeEnable) mem[ram_address] = ram_dataIn;

    typedef struct {
        logic             port;
        logic [WIDTH-1:0] rdata;
        logic             err;
        int unsigned      cyc;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int unsigned cyc        = 0;
    logic        pend_we    = 1'b0;
    int          gcnt[2]    = '{0, 0};
    int          first_grant = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic port, input logic [AW-1:0] a, input logic we,
                                 input logic [WIDTH-1:0] d);
        exp_t e;
        e.port = port;
        e.cyc  = cyc + 2;
        e.err  = (a >= DEPTH);
        if (e.err) begin
            e.rdata = '0;
        end else if (we) begin
            ref_mem[a[7:0]] = d;
            e.rdata = d;
        end else begin
            e.rdata = ref_mem[a[7:0]];
        end
        pend_we = we && !e.err;
        gcnt[port]++;
        if (first_grant < 0) first_grant = port;
        sb.push_back(e);
    endfunction

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            pend_we = 1'b0;
        end else begin
            exp_t e;
            logic             gport;
            logic [WIDTH-1:0] gdata;
            logic             gerr;
            chk("we_window", {31'b0, ram_writeEnable}, {31'b0, pend_we});
            chk("one_ready", {31'b0, p0_ready & p1_ready}, '0);
            chk("one_rsp",   {31'b0, p0_rsp_valid & p1_rsp_valid}, '0);
            pend_we = 1'b0;
            if (p0_valid && p0_ready) push(1'b0, p0_addr, p0_we, p0_wdata);
            if (p1_valid && p1_ready) push(1'b1, p1_addr, p1_we, p1_wdata);
            if (p0_rsp_valid || p1_rsp_valid) begin
                chk("rsp_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e     = sb.pop_front();
                    gport = p1_rsp_valid;
                    gdata = gport ? p1_rsp_rdata : p0_rsp_rdata;
                    gerr  = gport ? p1_rsp_err   : p0_rsp_err;
                    chk("rsp_port",  {31'b0, gport}, {31'b0, e.port});
                    chk("rsp_rdata", gdata, e.rdata);
                    chk("rsp_err",   {31'b0, gerr}, {31'b0, e.err});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input int port, input logic v, input logic [AW-1:0] a,
                         input logic we, input logic [WIDTH-1:0] d);
        if (port == 1) begin
            p1_valid = v; p1_addr = a; p1_we = we; p1_wdata = d;
        end else begin
            p0_valid = v; p0_addr = a; p0_we = we; p0_wdata = d;
        end
    endtask

    task automatic wait_accept(input int port);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port == 1) ? p1_ready : p0_ready) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", {31'b0, ok}, 32'd1);
        @(posedge clk);
    endtask

    task automatic req(input int port, input logic [AW-1:0] a, input logic we, input logic [WIDTH-1:0] d);
        drive(port, 1'b1, a, we, d);
        wait_accept(port);
        #1 drive(port, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_p0_rsp_valid"}, {31'b0, p0_rsp_valid}, '0);
        chk({tag, "_p1_rsp_valid"}, {31'b0, p1_rsp_valid}, '0);
        chk({tag, "_p0_rsp_err"},   {31'b0, p0_rsp_err}, '0);
        chk({tag, "_p1_rsp_err"},   {31'b0, p1_rsp_err}, '0);
        chk({tag, "_p0_rsp_rdata"}, p0_rsp_rdata, '0);
        chk({tag, "_p1_rsp_rdata"}, p1_rsp_rdata, '0);
        chk({tag, "_ram_address"},  {24'b0, ram_address}, '0);
        chk({tag, "_ram_dataIn"},   ram_dataIn, '0);
        chk({tag, "_ram_we"},       {31'b0, ram_writeEnable}, '0);
        chk({tag, "_p0_ready"},     {31'b0, p0_ready}, '0);
        chk({tag, "_p1_ready"},     {31'b0, p1_ready}, '0);
    endtask

    task automatic reset_mid(input int port, input logic [AW-1:0] a, input logic we, input logic [WIDTH-1:0] d);
        drive(port, 1'b1, a, we, d);
        wait_accept(port);
        #2;
        if (we) chk("mid_we_before_reset", {31'b0, ram_writeEnable}, 32'd1);
        reset = 1'b1;
        sb.delete();
        #1 chk_reset_outputs("mid_reset");
        @(posedge clk); #1 drive(port, 1'b0, '0, 1'b0, '0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 ^ i;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h00C0_FFEE;
        mem[5] = 32'hDEAD_BEEF;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];

        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic read
        req(0, 5, 1'b0, '0);
        drain();
        chk("basic_rdata_hold", p0_rsp_rdata, 32'hDEAD_BEEF);

        // Write then read, second accept overlaps the first response
        req(1, 10, 1'b1, 32'h1234_5678);
        req(0, 10, 1'b0, '0);
        drain();
        chk("wr_p1_rdata", p1_rsp_rdata, 32'h1234_5678);
        chk("rd_p0_rdata", p0_rsp_rdata, 32'h1234_5678);

        // Cross-port read-after-write
        req(0, 200, 1'b1, 32'h0BAD_F00D);
        req(1, 200, 1'b0, '0);
        drain();
        chk("raw_p1_rdata", p1_rsp_rdata, 32'h0BAD_F00D);

        // Out of range write and read
        req(1, 256, 1'b1, 32'hCAFE_F00D);
        drain();
        chk("oor_mem0_unchanged", mem[0], 32'h1111_0000);
        chk("oor_p1_rdata_zero", p1_rsp_rdata, '0);
        req(0, 300, 1'b0, '0);
        drain();
        chk("oor_p0_rdata_zero", p0_rsp_rdata, '0);

        // Reset mid-access, then a normal read
        reset_mid(1, 20, 1'b1, 32'h5555_AAAA);
        reset_mid(0, 7, 1'b0, '0);
        req(0, 5, 1'b0, '0);
        drain();
        chk("post_reset_read", p0_rsp_rdata, 32'hDEAD_BEEF);

        // Fresh reset, then both ports contend continuously for four slots
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1 reset = 1'b0;
        gcnt[0] = 0;
        gcnt[1] = 0;
        first_grant = -1;
        drive(0, 1'b1, 1, 1'b0, '0);
        drive(1, 1'b1, 1, 1'b0, '0);
        for (int i = 0; i < 40 && (gcnt[0] + gcnt[1]) < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, 1'b0, '0);
        drain();
        chk("contend_total", gcnt[0] + gcnt[1], 32'd4);
        chk("contend_p1_rdata", p1_rsp_rdata, 32'h00C0_FFEE);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("rr_first_grant", first_grant, 32'd0);
        chk("rr_p0_grants", gcnt[0], 32'd2);
        chk("rr_p1_grants", gcnt[1], 32'd2);
`else
        chk("fp_first_grant", first_grant, 32'd1);
        chk("fp_p0_grants", gcnt[0], 32'd0);
        chk("fp_p1_grants", gcnt[1], 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
